instruction_fetch: RTL and testbench

Wishbone initiator that fetches 32-bit instruction words sequentially from a program counter and presents them, tagged with their PC, to the decode stage through a valid/ready buffer. It sits between the core's front end and the instruction-memory slave on the shared `wishbone_if`. It keeps at most one bus transaction outstanding, supports PC redirect (branch/jump/trap) with discard of in-flight data, and flags a bus timeout.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/wishbone_if.sv | 24 ++
 rtl/fetch_fifo.sv | 55 +++++
 rtl/instruction_fetch.sv | 147 ++++++++++++++
 tb/tb_instruction_fetch.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states, buffer entry
// layout and Wishbone constants.
package fetch_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned WB_SEL_W = 4;

  localparam logic [WB_SEL_W-1:0] WB_SEL_ALL = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/wishbone_if.sv
// Classic Wishbone bus between the fetch initiator and instruction memory.
interface wishbone_if;
  import fetch_pkg::*;

  logic                cycle;
  logic                strobe;
  logic [XLEN-1:0]     address;
  logic                write_enable;
  logic [WB_SEL_W-1:0] select;
  logic [XLEN-1:0]     data_in;
  logic                ack;
  logic [XLEN-1:0]     data_out;

  modport master (
    output cycle, strobe, address, write_enable, select, data_in,
    input  ack, data_out
  );

  modport slave (
    input  cycle, strobe, address, write_enable, select, data_in,
    output ack, data_out
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush beats push and pop,
// push on full and pop on empty are ignored.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           din,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Sequential Wishbone instruction fetcher with one outstanding request,
// PC redirect with in-flight discard, and a sticky bus-timeout flag.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  wishbone_if.master         wishbone,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [XLEN-1:0]    instr_data,
  output logic [XLEN-1:0]    instr_pc,
  output logic               bus_error
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [XLEN-1:0] addr_q, addr_next;
  logic            cyc_q, cyc_next;
  logic            discard, discard_next;
  logic [TW-1:0]   tcnt, tcnt_next;
  logic            err_next;
  logic            push, flush, pop;

  fetch_entry_t    push_entry, head;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full_unused;
  logic            fifo_empty;

  assign push_entry = '{pc: pc, instr: wishbone.data_out};
  assign pop        = instr_ready && !fifo_empty;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (push_entry),
    .head  (head),
    .count (fifo_count),
    .full  (fifo_full_unused),
    .empty (fifo_empty)
  );

  // Next-state and registered-output computation
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    addr_next    = addr_q;
    cyc_next     = cyc_q;
    discard_next = discard;
    tcnt_next    = tcnt;
    err_next     = bus_error;
    push         = 1'b0;
    flush        = 1'b0;

    if (redirect_valid) begin
      flush    = 1'b1;
      pc_next  = {redirect_pc[XLEN-1:2], 2'b00};
      err_next = 1'b0;
    end

    case (state)
      IDLE: begin
        if (!redirect_valid && (fifo_count < CW'(FIFO_DEPTH))) begin
          cyc_next   = 1'b1;
          addr_next  = pc;
          tcnt_next  = '0;
          state_next = REQUEST;
        end
      end
      REQUEST: begin
        if (wishbone.ack) begin
          cyc_next     = 1'b0;
          discard_next = 1'b0;
          state_next   = IDLE;
          if (!discard && !redirect_valid) begin
            push    = 1'b1;
            pc_next = pc + 32'd4;
          end
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          // A redirect landing on the timeout cycle wins over the error
          cyc_next     = 1'b0;
          discard_next = 1'b0;
          if (redirect_valid) begin
            state_next = IDLE;
          end else begin
            err_next   = 1'b1;
            state_next = HALT;
          end
        end else begin
          tcnt_next = tcnt + 1'b1;
          if (redirect_valid) discard_next = 1'b1;
        end
      end
      HALT: begin
        if (redirect_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_PC;
      addr_q    <= RESET_PC;
      cyc_q     <= 1'b0;
      discard   <= 1'b0;
      tcnt      <= '0;
      bus_error <= 1'b0;
    end else begin
      pc        <= pc_next;
      addr_q    <= addr_next;
      cyc_q     <= cyc_next;
      discard   <= discard_next;
      tcnt      <= tcnt_next;
      bus_error <= err_next;
    end
  end

  assign wishbone.cycle        = cyc_q;
  assign wishbone.strobe       = cyc_q;
  assign wishbone.address      = addr_q;
  assign wishbone.write_enable = 1'b0;
  assign wishbone.select       = WB_SEL_ALL;
  assign wishbone.data_in      = '0;

  assign instr_valid = !fifo_empty;
  assign instr_data  = head.instr;
  assign instr_pc    = head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch against a two-edge-latency memory slave.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        bus_error;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic mute   = 1'b0;
  logic prev_cycle = 1'b0;
  logic [1:0] sc;

  logic [31:0] got_pc[$];
  logic [31:0] got_data[$];
  int          got_cyc[$];
  logic [31:0] req_addr[$];

  wishbone_if wb();

  instruction_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .wishbone       (wb),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .bus_error      (bus_error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    if (a[31:4] == 28'h0) w = 32'(a[3:2]) * 32'h11 + 32'h11;
    else                  w = a ^ 32'hC000_0000;
    return w;
  endfunction

  // Memory slave: acks on the second edge after it first samples strobe
  always @(posedge clk or posedge reset) begin
    if (reset || !wb.cycle) begin
      wb.ack <= 1'b0;
      sc     <= 2'd0;
      if (reset) wb.data_out <= 32'h0;
    end else if (wb.ack) begin
      wb.ack <= 1'b0;
      sc     <= 2'd0;
    end else if (wb.strobe && !mute) begin
      if (sc == 2'd1) begin
        wb.ack      <= 1'b1;
        wb.data_out <= mem_word(wb.address);
      end else begin
        sc <= sc + 2'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_logs();
    got_pc.delete(); got_data.delete(); got_cyc.delete(); req_addr.delete();
  endtask

  // Advance n cycles, logging consumed entries and new bus requests
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (instr_valid && instr_ready) begin
        got_pc.push_back(instr_pc);
        got_data.push_back(instr_data);
        got_cyc.push_back(cyc);
      end
      step();
      if (wb.cycle && !prev_cycle) req_addr.push_back(wb.address);
      prev_cycle = wb.cycle;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    #2;
    step(); step();
    reset = 1'b0;
    prev_cycle = 1'b0;
    clear_logs();
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
    prev_cycle     = wb.cycle;
  endtask

  initial begin
    instr_ready = 1'b1;
    do_reset();

    // Reset state
    check("rst_cycle", 32'(wb.cycle), 32'd0);
    check("rst_strobe", 32'(wb.strobe), 32'd0);
    check("rst_addr", wb.address, 32'h0);
    check("rst_we_sel", {27'd0, wb.write_enable, wb.select}, 32'h0000_000F);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_data_pc", instr_data | instr_pc, 32'h0);
    check("rst_err", 32'(bus_error), 32'd0);

    // Sequential fetch of words 0..3, one per 4 cycles
    run(17);
    check("seq_count", 32'(got_pc.size()), 32'd4);
    if (got_pc.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("seq_pc", got_pc[k], 32'(4 * k));
        check("seq_data", got_data[k], 32'(17 * (k + 1)));
      end
      check("seq_first_lat", 32'(got_cyc[0] - got_cyc[0 + 0] + got_cyc[1] - got_cyc[0]), 32'd4);
      check("seq_spacing", 32'(got_cyc[3] - got_cyc[1]), 32'd8);
    end

    // Decode stalled: two fetches fill the buffer, bus then idles
    do_reset();
    instr_ready = 1'b0;
    run(20);
    check("stall_reqs", 32'(req_addr.size()), 32'd2);
    check("stall_cycle", 32'(wb.cycle), 32'd0);
    check("stall_head_pc", instr_pc, 32'h0);
    clear_logs();
    instr_ready = 1'b1;
    run(12);
    check("resume_addr", (req_addr.size() > 0) ? req_addr[0] : 32'hDEAD_BEEF, 32'h8);
    check("resume_n", 32'(got_pc.size() >= 3), 32'd1);
    if (got_pc.size() >= 3) begin
      check("resume_pc1", got_pc[1], 32'h4);
      check("resume_pc2", got_pc[2], 32'h8);
      check("resume_d2", got_data[2], 32'h33);
    end

    // Redirect while the PC 4 request is in flight
    do_reset();
    instr_ready = 1'b0;
    for (int k = 0; k < 20 && !(wb.cycle && wb.address == 32'h4); k++) step();
    check("rd_req4", 32'(wb.cycle && wb.address == 32'h4), 32'd1);
    redirect(32'h100);
    check("rd_flushed", 32'(instr_valid), 32'd0);
    check("rd_held", 32'(wb.cycle), 32'd1);
    instr_ready = 1'b1;
    clear_logs();
    run(12);
    check("rd_req", (req_addr.size() > 0) ? req_addr[0] : 32'hDEAD_BEEF, 32'h100);
    check("rd_pc", (got_pc.size() > 0) ? got_pc[0] : 32'hDEAD_BEEF, 32'h100);
    check("rd_data", (got_data.size() > 0) ? got_data[0] : 32'hDEAD_BEEF, 32'hC000_0100);

    // Redirect coincident with ack, unaligned target
    do_reset();
    for (int k = 0; k < 20 && !wb.ack; k++) step();
    check("ra_ack_seen", 32'(wb.ack), 32'd1);
    redirect(32'h103);
    check("ra_no_stale", 32'(instr_valid), 32'd0);
    check("ra_cycle", 32'(wb.cycle), 32'd0);
    clear_logs();
    run(10);
    check("ra_req", (req_addr.size() > 0) ? req_addr[0] : 32'hDEAD_BEEF, 32'h100);
    check("ra_pc", (got_pc.size() > 0) ? got_pc[0] : 32'hDEAD_BEEF, 32'h100);

    // Slave never acks: timeout on the 16th REQUEST cycle
    mute = 1'b1;
    do_reset();
    for (int k = 0; k < 5 && !wb.cycle; k++) step();
    check("to_started", 32'(wb.cycle), 32'd1);
    repeat (15) step();
    check("to_before", {30'd0, wb.cycle, bus_error}, 32'h2);
    step();
    check("to_fired", {30'd0, wb.cycle, bus_error}, 32'h1);
    prev_cycle = wb.cycle;
    clear_logs();
    run(10);
    check("to_halted", 32'(req_addr.size()), 32'd0);
    check("to_sticky", 32'(bus_error), 32'd1);
    mute = 1'b0;
    redirect(32'h40);
    check("to_cleared", 32'(bus_error), 32'd0);
    clear_logs();
    run(10);
    check("to_resume_req", (req_addr.size() > 0) ? req_addr[0] : 32'hDEAD_BEEF, 32'h40);
    check("to_resume_data", (got_data.size() > 0) ? got_data[0] : 32'hDEAD_BEEF, 32'hC000_0040);

    // PC wraps from the top of the address space
    do_reset();
    redirect(32'hFFFF_FFFC);
    clear_logs();
    run(12);
    check("wrap_req0", (req_addr.size() > 0) ? req_addr[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    check("wrap_req1", (req_addr.size() > 1) ? req_addr[1] : 32'hDEAD_BEEF, 32'h0);
    check("wrap_data", (got_data.size() > 0) ? got_data[0] : 32'hDEAD_BEEF, 32'h3FFF_FFFC);

    // Asynchronous reset mid-REQUEST
    for (int k = 0; k < 10 && !wb.cycle; k++) step();
    check("ar_in_req", 32'(wb.cycle), 32'd1);
    reset = 1'b1;
    #1;
    check("ar_drop", {30'd0, wb.cycle, wb.strobe}, 32'h0);
    check("ar_addr", wb.address, 32'h0);
    #1;
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
